// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART TX arbiter and related UART blocks.
package uart_pkg;

  localparam int unsigned BYTE_W = 8;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StStart,
    StWaitAck,
    StWaitDone,
    StGap
  } state_e;

  // Ceiling log2 with a floor of 1 so single-entry vectors still get a bit.
  function automatic int unsigned clog2_w(input int unsigned n);
    int unsigned r;
    r = 1;
    while ((32'd1 << r) < n) begin
      r++;
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request strictly after the pointer.
module rr_pick #(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = 2
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic          o_found,
  output logic [IW-1:0] o_idx
);

  int unsigned w_cand;

  always_comb begin
    o_found = 1'b0;
    o_idx   = '0;
    w_cand  = 0;
    for (int unsigned k = 1; k <= N; k++) begin
      w_cand = (32'(i_ptr) + k) % N;
      if (!o_found && i_req[w_cand[IW-1:0]]) begin
        o_found = 1'b1;
        o_idx   = w_cand[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin arbiter sharing one UART TX byte port between NREQ requesters.
// Optional inter-packet idle gap enabled by defining UART_TX_ARB_GAP_EN.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int unsigned NREQ        = 4,
  parameter int unsigned STALL_LIMIT = 1024,
  parameter int unsigned GAP_CYCLES  = 64
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NREQ-1:0]             i_req_valid,
  input  logic [BYTE_W*NREQ-1:0]      i_req_data,
  input  logic [NREQ-1:0]             i_req_last,
  output logic [NREQ-1:0]             o_req_ready,
  output logic                        o_tx_start,
  output logic [BYTE_W-1:0]           o_tx_data,
  input  logic                        i_tx_busy,
  output logic [clog2_w(NREQ)-1:0]    o_grant_id,
  output logic                        o_active,
  output logic                        o_stall_abort
);

  localparam int unsigned IDW = clog2_w(NREQ);
  localparam int unsigned SCW = clog2_w(STALL_LIMIT + 1);

`ifdef UART_TX_ARB_GAP_EN
  localparam int unsigned GCW = clog2_w(GAP_CYCLES + 1);
  localparam state_e StPktEnd = StGap;
`else
  localparam state_e StPktEnd = StIdle;
`endif

  state_e            r_state, w_state_nx;
  logic [IDW-1:0]    r_ptr, w_ptr_nx;
  logic [IDW-1:0]    r_grant, w_grant_nx;
  logic              r_active, w_active_nx;
  logic [BYTE_W-1:0] r_tx_data, w_tx_data_nx;
  logic              r_last, w_last_nx;
  logic [SCW-1:0]    r_stall_cnt, w_stall_cnt_nx;
`ifdef UART_TX_ARB_GAP_EN
  logic [GCW-1:0]    r_gap_cnt, w_gap_cnt_nx;
`endif

  logic              w_found;
  logic [IDW-1:0]    w_pick;
  logic              w_sel_valid;
  logic              w_sel_last;
  logic [BYTE_W-1:0] w_sel_data;
  logic              w_stall_hit;

  rr_pick #(
    .N  (NREQ),
    .IW (IDW)
  ) u_rr_pick (
    .i_req   (i_req_valid),
    .i_ptr   (r_ptr),
    .o_found (w_found),
    .o_idx   (w_pick)
  );

  assign w_sel_valid = i_req_valid[r_grant];
  assign w_sel_last  = i_req_last[r_grant];
  assign w_sel_data  = i_req_data[r_grant*BYTE_W +: BYTE_W];
  assign w_stall_hit = (STALL_LIMIT != 0) && (32'(r_stall_cnt) == STALL_LIMIT - 1);

  always_comb begin
    w_state_nx     = r_state;
    w_ptr_nx       = r_ptr;
    w_grant_nx     = r_grant;
    w_active_nx    = r_active;
    w_tx_data_nx   = r_tx_data;
    w_last_nx      = r_last;
    w_stall_cnt_nx = r_stall_cnt;
`ifdef UART_TX_ARB_GAP_EN
    w_gap_cnt_nx   = r_gap_cnt;
`endif
    o_req_ready    = '0;
    o_tx_start     = 1'b0;
    o_stall_abort  = 1'b0;

    case (r_state)
      StIdle: begin
        if (w_found) begin
          w_grant_nx     = w_pick;
          w_active_nx    = 1'b1;
          w_stall_cnt_nx = '0;
          w_state_nx     = StLoad;
        end
      end

      StLoad: begin
        o_req_ready[r_grant] = w_sel_valid;
        if (w_sel_valid) begin
          w_tx_data_nx   = w_sel_data;
          w_last_nx      = w_sel_last;
          w_stall_cnt_nx = '0;
          w_state_nx     = StStart;
        end else if (w_stall_hit) begin
          // Revoke the grant; pointer moves past the stalled requester.
          o_stall_abort  = 1'b1;
          w_active_nx    = 1'b0;
          w_ptr_nx       = r_grant;
          w_stall_cnt_nx = '0;
          w_state_nx     = StPktEnd;
        end else if (STALL_LIMIT != 0) begin
          w_stall_cnt_nx = r_stall_cnt + 1'b1;
        end
      end

      StStart: begin
        // Hold the start while an external user keeps the transmitter busy.
        o_tx_start = 1'b1;
        if (!i_tx_busy) begin
          w_state_nx = StWaitAck;
        end
      end

      StWaitAck: begin
        if (i_tx_busy) begin
          w_state_nx = StWaitDone;
        end
      end

      StWaitDone: begin
        if (!i_tx_busy) begin
          if (r_last) begin
            w_ptr_nx    = r_grant;
            w_active_nx = 1'b0;
            w_state_nx  = StPktEnd;
          end else begin
            w_state_nx  = StLoad;
          end
        end
      end

`ifdef UART_TX_ARB_GAP_EN
      StGap: begin
        if (32'(r_gap_cnt) + 32'd1 >= GAP_CYCLES) begin
          w_gap_cnt_nx = '0;
          w_state_nx   = StIdle;
        end else begin
          w_gap_cnt_nx = r_gap_cnt + 1'b1;
        end
      end
`endif

      default: begin
        w_state_nx = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= StIdle;
      r_ptr       <= IDW'(NREQ - 1);
      r_grant     <= '0;
      r_active    <= 1'b0;
      r_tx_data   <= '0;
      r_last      <= 1'b0;
      r_stall_cnt <= '0;
`ifdef UART_TX_ARB_GAP_EN
      r_gap_cnt   <= '0;
`endif
    end else begin
      r_state     <= w_state_nx;
      r_ptr       <= w_ptr_nx;
      r_grant     <= w_grant_nx;
      r_active    <= w_active_nx;
      r_tx_data   <= w_tx_data_nx;
      r_last      <= w_last_nx;
      r_stall_cnt <= w_stall_cnt_nx;
`ifdef UART_TX_ARB_GAP_EN
      r_gap_cnt   <= w_gap_cnt_nx;
`endif
    end
  end

  assign o_grant_id = r_grant;
  assign o_active   = r_active;
  assign o_tx_data  = r_tx_data;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: requester sources, a busy-model transmitter, ordered expects.
module tb_uart_tx_arbiter;

  localparam int unsigned NREQ     = 4;
  localparam int unsigned STALL    = 16;
  localparam int unsigned GAP      = 64;
  localparam int unsigned BUSY_CYC = 20;
`ifdef UART_TX_ARB_GAP_EN
  localparam int GapExp = GAP + 2;
`else
  localparam int GapExp = 2;
`endif

  logic              clk;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid;
  logic [8*NREQ-1:0] req_data;
  logic [NREQ-1:0]   req_last;
  logic [NREQ-1:0]   req_ready;
  logic              tx_start;
  logic [7:0]        tx_data;
  logic              tx_busy;
  logic [1:0]        grant_id;
  logic              active;
  logic              stall_abort;

  uart_tx_arbiter #(
    .NREQ        (NREQ),
    .STALL_LIMIT (STALL),
    .GAP_CYCLES  (GAP)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_req_valid   (req_valid),
    .i_req_data    (req_data),
    .i_req_last    (req_last),
    .o_req_ready   (req_ready),
    .o_tx_start    (tx_start),
    .o_tx_data     (tx_data),
    .i_tx_busy     (tx_busy),
    .o_grant_id    (grant_id),
    .o_active      (active),
    .o_stall_abort (stall_abort)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc      = 0;
  logic [8:0]  src_q [NREQ][$];   // {last, data}
  logic [NREQ-1:0] src_en = '1;
  logic [NREQ-1:0] acc    = '0;
  logic [10:0] exp_q [$];         // {id, data} in expected line order
  int          model_cnt  = 0;
  logic        model_busy = 1'b0;
  logic        ext_busy   = 1'b0;
  int          n_tx       = 0;

  assign tx_busy = model_busy | ext_busy;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #2;
    cyc++;
  endtask

  task automatic push_byte(input int id, input logic [7:0] d, input logic l, input bit expect_tx);
    src_q[id].push_back({l, d});
    if (expect_tx) exp_q.push_back({3'(id), d});
  endtask

  task automatic clear_sources();
    for (int i = 0; i < NREQ; i++) src_q[i].delete();
    acc = '0;
  endtask

  task automatic apply_reset();
    step();
    #1 rst_n = 1'b0;
    clear_sources();
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic wait_until_idle(input string tag);
    int  n;
    bit  ok;
    n  = 0;
    ok = 1'b0;
    while (!ok && n < 3000) begin
      step();
      n++;
      if (exp_q.size() == 0 && !active && !model_busy) ok = 1'b1;
    end
    check_eq(tag, 32'(ok), 32'd1);
  endtask

  task automatic check_reset_outputs(input string pfx);
    check_eq({pfx, "_ready"}, 32'(req_ready), 32'd0);
    check_eq({pfx, "_start"}, 32'(tx_start), 32'd0);
    check_eq({pfx, "_data"}, 32'(tx_data), 32'd0);
    check_eq({pfx, "_gid"}, 32'(grant_id), 32'd0);
    check_eq({pfx, "_active"}, 32'(active), 32'd0);
    check_eq({pfx, "_abort"}, 32'(stall_abort), 32'd0);
  endtask

  // Requester sources: present queue heads at negedge, record handshakes just before posedge.
  initial begin
    logic [8:0] head;
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < NREQ; i++)
        if (acc[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
      acc = '0;
      for (int i = 0; i < NREQ; i++) begin
        if (src_en[i] && src_q[i].size() > 0) begin
          head = src_q[i][0];
          req_valid[i]        = 1'b1;
          req_data[8*i +: 8]  = head[7:0];
          req_last[i]         = head[8];
        end else begin
          req_valid[i]        = 1'b0;
          req_data[8*i +: 8]  = 8'($urandom);
          req_last[i]         = 1'b1;
        end
      end
      #4;
      acc = req_valid & req_ready;
    end
  end

  // Transmitter model: latches on start while idle, busy for BUSY_CYC cycles from the next cycle.
  initial begin
    logic       s_start, s_busy;
    logic [7:0] s_data;
    logic [1:0] s_gid;
    logic [10:0] e;
    forever begin
      @(negedge clk);
      #4;
      s_start = tx_start;
      s_busy  = tx_busy;
      s_data  = tx_data;
      s_gid   = grant_id;
      @(posedge clk);
      #1;
      if (model_cnt > 0) model_cnt--;
      if (s_start && !s_busy) begin
        model_cnt = BUSY_CYC;
        n_tx++;
        if (exp_q.size() == 0) begin
          check_eq("tx_unexpected_byte", 32'(exp_q.size()), 32'd1);
        end else begin
          e = exp_q.pop_front();
          check_eq("tx_data", 32'(s_data), 32'(e[7:0]));
          check_eq("tx_grant_id", 32'(s_gid), 32'(e[10:8]));
        end
      end
      model_busy = (model_cnt != 0);
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int  n, last_fall, cnt, tx0;
    bit  ok;
    logic prev_busy;

    rst_n = 1'b0;
    #3;
    check_reset_outputs("reset");
    step();
    step();
    rst_n = 1'b1;

    // Single requester, three-byte packet, with first-byte latency checks.
    push_byte(1, 8'hA5, 1'b0, 1'b1);
    push_byte(1, 8'h5A, 1'b0, 1'b1);
    push_byte(1, 8'hFF, 1'b1, 1'b1);
    step();
    check_eq("lat_c0_active", 32'(active), 32'd0);
    step();
    check_eq("lat_c1_active", 32'(active), 32'd1);
    check_eq("lat_c1_gid", 32'(grant_id), 32'd1);
    check_eq("lat_c1_ready", 32'(req_ready), 32'b0010);
    step();
    check_eq("lat_c2_start", 32'(tx_start), 32'd1);
    check_eq("lat_c2_data", 32'(tx_data), 32'hA5);
    wait_until_idle("t1_done");
    check_eq("t1_gid", 32'(grant_id), 32'd1);

    // Three simultaneous two-byte packets delivered whole in order 0,1,2.
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      push_byte(i, 8'h10 + 8'(i), 1'b0, 1'b1);
      push_byte(i, 8'h20 + 8'(i), 1'b1, 1'b1);
    end
    wait_until_idle("t2_done");

    // Requesters 0 and 3 together: 3 first; measure busy-fall to next grant.
    push_byte(3, 8'h31, 1'b0, 1'b1);
    push_byte(3, 8'h32, 1'b1, 1'b1);
    push_byte(0, 8'h01, 1'b1, 1'b1);
    n = 0; ok = 1'b0; last_fall = 0; prev_busy = tx_busy;
    while (!ok && n < 3000) begin
      step();
      n++;
      if (prev_busy && !tx_busy) last_fall = cyc;
      prev_busy = tx_busy;
      if (active && grant_id == 2'd0) ok = 1'b1;
    end
    check_eq("t2b_grant0_seen", 32'(ok), 32'd1);
    check_eq("t2b_gap_cycles", 32'(cyc - last_fall), 32'(GapExp));
    wait_until_idle("t2b_done");

    // Requester 2 stalls after its first byte; requester 3 takes over.
    push_byte(2, 8'h11, 1'b0, 1'b1);
    push_byte(2, 8'h22, 1'b1, 1'b0);
    push_byte(3, 8'h33, 1'b1, 1'b1);
    n = 0;
    while (src_q[2].size() != 1 && n < 200) begin
      step();
      n++;
    end
    src_en[2] = 1'b0;
    n = 0; ok = 1'b0; last_fall = 0; prev_busy = tx_busy;
    while (!ok && n < 3000) begin
      step();
      n++;
      if (prev_busy && !tx_busy) last_fall = cyc;
      prev_busy = tx_busy;
      if (stall_abort) ok = 1'b1;
    end
    check_eq("t3_abort_seen", 32'(ok), 32'd1);
    check_eq("t3_abort_delay", 32'(cyc - last_fall), 32'(STALL));
    step();
    check_eq("t3_abort_pulse", 32'(stall_abort), 32'd0);
    check_eq("t3_active_low", 32'(active), 32'd0);
    wait_until_idle("t3_done");
    check_eq("t3_next_gid", 32'(grant_id), 32'd3);
    src_q[2].delete();
    src_en[2] = 1'b1;

    // External user holds the transmitter busy: start is held, one byte goes out.
    ext_busy = 1'b1;
    tx0 = n_tx;
    push_byte(1, 8'h77, 1'b1, 1'b1);
    n = 0;
    while (!tx_start && n < 200) begin
      step();
      n++;
    end
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (tx_start) cnt++;
    end
    check_eq("t4_start_held", 32'(cnt), 32'd8);
    ext_busy = 1'b0;
    wait_until_idle("t4_done");
    check_eq("t4_one_byte", 32'(n_tx - tx0), 32'd1);

    // Reset during the first byte of a two-byte packet; afterwards requester 0 wins.
    push_byte(2, 8'hC3, 1'b0, 1'b1);
    push_byte(2, 8'h3C, 1'b1, 1'b0);
    n = 0;
    while (!(model_busy && active) && n < 200) begin
      step();
      n++;
    end
    step();
    step();
    step();
    #1 rst_n = 1'b0;
    #1 check_reset_outputs("midrst");
    clear_sources();
    step();
    step();
    rst_n = 1'b1;
    push_byte(0, 8'hD0, 1'b1, 1'b1);
    push_byte(3, 8'hD1, 1'b1, 1'b1);
    wait_until_idle("t5_done");

    check_eq("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
